// File: rtl/bist_controller.sv
// ---------------------------------------------------------------------------
// bist_controller
//
// Top-level sequencer for the BIST engine. One start request produces:
// one INIT cycle, then N_SESSIONS sessions of N_CYCLES running cycles, then
// one FINISH cycle, after which the controller parks in DONE with bist_end
// held high until the next run begins or reset.
//
// Optional behaviour (macro BIST_RESTART_ON_START_EN):
//   defined   - a start request seen in RUN or FINISH aborts the current run
//               and restarts the full sequence from INIT.
//   undefined - start during INIT/RUN/FINISH is ignored and discarded.
//
// Ports:
//   clk       in   system clock, rising-edge active
//   reset     in   asynchronous, active-high reset
//   start     in   start request; may be a sub-period asynchronous pulse
//   init      out  one-cycle pulse, initialises pattern gen / compactor
//   running   out  high during every test cycle of every session
//   toggle    out  one-cycle pulse on the last cycle of each non-final session
//   finish    out  one-cycle pulse after the final test cycle
//   bist_end  out  run-completed level, from the finish cycle until next run
//
// All outputs are registered and decoded from the next state / counters, so
// each output is a clean flop with no combinational path from start.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for first start request, all outputs low
//   INIT   | init pulse, counters cleared
//   RUN    | test cycles, cycle/session counters advance
//   FINISH | finish pulse, bist_end rises
//   DONE   | bist_end held, waiting for the next start request
// ---------------------------------------------------------------------------
module bist_controller #(
    parameter int N_CYCLES   = 4,
    parameter int N_SESSIONS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic init,
    output logic running,
    output logic toggle,
    output logic finish,
    output logic bist_end
);

    localparam int CW = (N_CYCLES > 1) ? $clog2(N_CYCLES) : 1;
    localparam int SW = (N_SESSIONS > 1) ? $clog2(N_SESSIONS) : 1;

    localparam logic [CW-1:0] CYC_LAST = CW'(N_CYCLES - 1);
    localparam logic [SW-1:0] SES_LAST = SW'(N_SESSIONS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        RUN    = 3'd2,
        FINISH = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CW-1:0]  cyc;
    logic [CW-1:0]  cyc_nxt;
    logic [SW-1:0]  ses;
    logic [SW-1:0]  ses_nxt;

    logic           start_req;
    logic           req_clr;
    logic           waiting;

    logic           init_nxt;
    logic           running_nxt;
    logic           toggle_nxt;
    logic           finish_nxt;
    logic           bist_end_nxt;

    // -----------------------------------------------------------------------
    // Start capture. The flag is set asynchronously by the start level so a
    // pulse narrower than a clock period is not lost. Reset has priority, so
    // nothing is captured while reset is high. On clock edges the flag is
    // cleared whenever it has been consumed (leaving IDLE/DONE) or whenever
    // the FSM is busy (request discarded); a start still high at that edge
    // re-asserts it through the start branch.
    // -----------------------------------------------------------------------
    assign waiting = (state == IDLE) || (state == DONE);
    assign req_clr = !waiting || start_req;

    always_ff @(posedge clk or posedge reset or posedge start) begin
        if (reset) begin
            start_req <= 1'b0;
        end else if (start) begin
            start_req <= 1'b1;
        end else if (req_clr) begin
            start_req <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State, counter and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cyc      <= '0;
            ses      <= '0;
            init     <= 1'b0;
            running  <= 1'b0;
            toggle   <= 1'b0;
            finish   <= 1'b0;
            bist_end <= 1'b0;
        end else begin
            state    <= state_nxt;
            cyc      <= cyc_nxt;
            ses      <= ses_nxt;
            init     <= init_nxt;
            running  <= running_nxt;
            toggle   <= toggle_nxt;
            finish   <= finish_nxt;
            bist_end <= bist_end_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and counter logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc;
        ses_nxt   = ses;

        unique case (state)
            IDLE: begin
                if (start_req) begin
                    state_nxt = INIT;
                end
            end

            INIT: begin
                cyc_nxt   = '0;
                ses_nxt   = '0;
                state_nxt = RUN;
            end

            RUN: begin
`ifdef BIST_RESTART_ON_START_EN
                if (start_req) begin
                    state_nxt = INIT;
                    cyc_nxt   = '0;
                    ses_nxt   = '0;
                end else
`endif
                if (cyc == CYC_LAST) begin
                    if (ses == SES_LAST) begin
                        // Counters stay at terminal count until INIT clears them.
                        state_nxt = FINISH;
                    end else begin
                        cyc_nxt = '0;
                        ses_nxt = ses + SW'(1);
                    end
                end else begin
                    cyc_nxt = cyc + CW'(1);
                end
            end

            FINISH: begin
`ifdef BIST_RESTART_ON_START_EN
                if (start_req) begin
                    state_nxt = INIT;
                    cyc_nxt   = '0;
                    ses_nxt   = '0;
                end else begin
                    state_nxt = DONE;
                end
`else
                state_nxt = DONE;
`endif
            end

            DONE: begin
                if (start_req) begin
                    state_nxt = INIT;
                end
            end

            default: begin
                state_nxt = IDLE;
                cyc_nxt   = '0;
                ses_nxt   = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode, evaluated on the next state so the registered outputs
    // line up with the cycle the FSM is in. Toggle marks the last cycle of
    // every session except the final one.
    // -----------------------------------------------------------------------
    always_comb begin
        init_nxt     = 1'b0;
        running_nxt  = 1'b0;
        toggle_nxt   = 1'b0;
        finish_nxt   = 1'b0;
        bist_end_nxt = 1'b0;

        unique case (state_nxt)
            INIT: begin
                init_nxt = 1'b1;
            end
            RUN: begin
                running_nxt = 1'b1;
                toggle_nxt  = (cyc_nxt == CYC_LAST) && (ses_nxt != SES_LAST);
            end
            FINISH: begin
                finish_nxt   = 1'b1;
                bist_end_nxt = 1'b1;
            end
            DONE: begin
                bist_end_nxt = 1'b1;
            end
            default: begin
                init_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bist_controller.sv
module tb_bist_controller;

    localparam int NC     = 4;
    localparam int NS     = 2;
    localparam int FIN_T  = NC * NS + 1;
    localparam int DONE_T = FIN_T + 1;
    localparam int NROWS  = 12;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic init, running, toggle, finish, bist_end;

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    bist_controller #(.N_CYCLES(NC), .N_SESSIONS(NS)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .init     (init),
        .running  (running),
        .toggle   (toggle),
        .finish   (finish),
        .bist_end (bist_end)
    );

    always #5 clk = ~clk;

    wire [4:0] outs = {init, running, toggle, finish, bist_end};

    // ---------------- behavioural reference model ----------------
    // A run is described by t = cycles since its INIT cycle (t=0).
    bit m_active = 1'b0;
    int m_t      = 0;
    bit m_req    = 1'b0;

    always @(posedge start) begin
        if (!reset) m_req = 1'b1;
    end

    always @(posedge clk or posedge reset) begin
        bit accept;
        if (reset) begin
            m_active = 1'b0;
            m_t      = 0;
            m_req    = 1'b0;
        end else begin
            accept = !m_active || (m_t == DONE_T);
`ifdef BIST_RESTART_ON_START_EN
            if (m_active && m_t >= 1 && m_t <= FIN_T) accept = 1'b1;
`endif
            if (m_req && accept) begin
                m_active = 1'b1;
                m_t      = 0;
            end else if (m_active && m_t < DONE_T) begin
                m_t = m_t + 1;
            end
            m_req = start;
        end
    end

    function automatic logic [4:0] model_outs();
        logic i, r, tg, f, be;
        if (!m_active) return 5'b0;
        i  = (m_t == 0);
        r  = (m_t >= 1) && (m_t <= NC * NS);
        tg = r && (m_t % NC == 0) && (m_t < NC * NS);
        f  = (m_t == FIN_T);
        be = (m_t >= FIN_T);
        return {i, r, tg, f, be};
    endfunction

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got {init,running,toggle,finish,bist_end}=%b expected %b",
                     name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) chk("model", outs, model_outs());
    end

    // ---------------- directed table ----------------
    typedef struct {
        int         cyc;
        logic [4:0] exp;
    } row_t;

    row_t seq[NROWS];

    // Called right after a falling edge; pulse ends well before the next rise.
    task automatic start_pulse();
        #1 start = 1'b1;
        #3 start = 1'b0;
    endtask

    // inj >= 0: inject a start pulse in the cycle of row inj.
    task automatic run_table(input string tag, input int inj);
        int n;
        int idx;
        n = NROWS;
`ifdef BIST_RESTART_ON_START_EN
        if (inj >= 0) n = NROWS + inj + 1;
`endif
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idx = i;
`ifdef BIST_RESTART_ON_START_EN
            if (inj >= 0 && i > inj) idx = i - inj - 1;
`endif
            chk($sformatf("%s[%0d]", tag, seq[idx].cyc), outs, seq[idx].exp);
            if (i == inj) start_pulse();
        end
    endtask

    initial begin
        // rows: {init, running, toggle, finish, bist_end}
        seq[0]  = '{0,  5'b10000};
        seq[1]  = '{1,  5'b01000};
        seq[2]  = '{2,  5'b01000};
        seq[3]  = '{3,  5'b01000};
        seq[4]  = '{4,  5'b01100};
        seq[5]  = '{5,  5'b01000};
        seq[6]  = '{6,  5'b01000};
        seq[7]  = '{7,  5'b01000};
        seq[8]  = '{8,  5'b01000};
        seq[9]  = '{9,  5'b00011};
        seq[10] = '{10, 5'b00001};
        seq[11] = '{11, 5'b00001};

        repeat (2) @(negedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_state", outs, 5'b0);
        mon_en = 1'b1;

        // 1: basic run from a narrow pulse
        start_pulse();
        run_table("run1", -1);

        // 2: second run after completion
        start_pulse();
        run_table("run2", -1);

        // 3: start in RUN (ignored in default build), then no spurious run
        start_pulse();
        run_table("start_in_run", 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("done_hold", outs, 5'b00001);
        end

        // 4: reset one cycle into RUN
        start_pulse();
        @(negedge clk);
        chk("rst_init", outs, 5'b10000);
        @(negedge clk);
        chk("rst_run1", outs, 5'b01000);
        #1 reset = 1'b1;
        #1 chk("async_reset", outs, 5'b0);
        #2 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_after_reset", outs, 5'b0);
        end
        start_pulse();
        run_table("after_reset", -1);

        // 5: start overlapping reset
        @(negedge clk);
        #1 reset = 1'b1;
        #1 start = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("start_under_reset", outs, 5'b0);
        end
        #1 reset = 1'b0;
        @(negedge clk);
        chk("reset_release", outs, 5'b0);
        #1 start = 1'b0;
        run_table("held_start", 5);
        repeat (3) @(negedge clk);

        // randomized phase, checked by the model monitor
        for (int c = 0; c < 600; c++) begin
            int r;
            @(negedge clk);
            r = $urandom_range(0, 99);
            if (r < 12) begin
                start_pulse();
            end else if (r < 14) begin
                #1 reset = 1'b1;
                #3 reset = 1'b0;
            end
        end

        @(negedge clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
